// File: rtl/mouse_packet_decoder_pkg.sv
// Shared constants for the PS/2 mouse packet decoder: FSM state encodings,
// status-byte bit positions and receive-error bit positions.
package mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_DX = 3'd1,
        ST_WAIT_DY = 3'd2,
        ST_WAIT_DZ = 3'd3,
        ST_UPDATE  = 3'd4
    } mouse_state_e;

    localparam int BTN_L  = 0;
    localparam int BTN_R  = 1;
    localparam int BTN_M  = 2;
    localparam int SYNC   = 3;
    localparam int X_SIGN = 4;
    localparam int Y_SIGN = 5;
    localparam int X_OVF  = 6;
    localparam int Y_OVF  = 7;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

endpackage

// File: rtl/mouse_packet_decoder_if.sv
// Byte stream from the PS/2 receiver into the packet decoder.
interface mouse_byte_if;
    logic [7:0] BYTE_IN;
    logic       BYTE_VALID;
    logic [1:0] BYTE_ERR;

    modport master (output BYTE_IN, output BYTE_VALID, output BYTE_ERR);
    modport slave  (input  BYTE_IN, input  BYTE_VALID, input  BYTE_ERR);
endinterface

// File: rtl/mouse_axis_clamp.sv
// One pointer axis: applies a signed 9-bit delta (zeroed on overflow) to an
// 8-bit position and clamps the result to 0..LIMIT-1. Purely combinational.
module mouse_axis_clamp #(
    parameter int LIMIT    = 160,
    parameter bit SUBTRACT = 1'b0
) (
    input  logic [7:0]        pos_i,
    input  logic signed [8:0] delta_i,
    input  logic              ovf_i,
    output logic [7:0]        pos_o
);
    localparam logic signed [9:0] MAX_POS = 10'(LIMIT - 1);

    logic signed [9:0] delta_ext;
    logic signed [9:0] sum;

    // 10 bits hold every pos +/- delta result without wrapping
    always_comb begin
        delta_ext = ovf_i ? 10'sd0 : {delta_i[8], delta_i};
        sum       = SUBTRACT ? ($signed({2'b00, pos_i}) - delta_ext)
                             : ($signed({2'b00, pos_i}) + delta_ext);
        if (sum[9]) begin
            pos_o = 8'd0;
        end else if (sum > MAX_POS) begin
            pos_o = MAX_POS[7:0];
        end else begin
            pos_o = sum[7:0];
        end
    end
endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles PS/2 mouse bytes into packets and keeps the clamped pointer position.
// Define MOUSE_SCROLL_EN for 4-byte IntelliMouse packets and the MouseZ output.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int MAX_X          = 160,
    parameter int MAX_Y          = 120,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    mouse_byte_if.slave byte_if,
    output logic [3:0]  MouseStatus,
    output logic [7:0]  MouseX,
    output logic [7:0]  MouseY,
`ifdef MOUSE_SCROLL_EN
    output logic [7:0]  MouseZ,
`endif
    output logic        SendInterrupt,
    output logic        PACKET_ERR
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] WAIT_DX = ST_WAIT_DX;
    localparam logic [2:0] WAIT_DY = ST_WAIT_DY;
    localparam logic [2:0] UPDATE  = ST_UPDATE;
`ifdef MOUSE_SCROLL_EN
    localparam logic [2:0] WAIT_DZ  = ST_WAIT_DZ;
    localparam logic [2:0] AFTER_DY = WAIT_DZ;
`else
    localparam logic [2:0] AFTER_DY = UPDATE;
`endif

    logic [2:0]       state_q, state_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       bx_q, bx_d;
    logic [7:0]       by_q, by_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0]       status_out_q;
    logic [7:0]       x_q, y_q;
    logic             int_q;
`ifdef MOUSE_SCROLL_EN
    logic [3:0]       bz_q, bz_d;
    logic [7:0]       z_q;
`endif

    logic       byte_ok, byte_bad, in_wait, upd;
    logic [7:0] x_next, y_next;

    assign byte_ok  = byte_if.BYTE_VALID && (byte_if.BYTE_ERR == 2'b00);
    assign byte_bad = byte_if.BYTE_VALID && (byte_if.BYTE_ERR != 2'b00);
    assign upd      = (state_q == UPDATE) && ENABLE;
`ifdef MOUSE_SCROLL_EN
    assign in_wait  = (state_q == WAIT_DX) || (state_q == WAIT_DY) || (state_q == WAIT_DZ);
`else
    assign in_wait  = (state_q == WAIT_DX) || (state_q == WAIT_DY);
`endif

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        bx_d     = bx_q;
        by_d     = by_q;
`ifdef MOUSE_SCROLL_EN
        bz_d     = bz_q;
`endif
        cnt_d    = '0;
        err_d    = 1'b0;
        if (in_wait) begin
            if (byte_bad) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (byte_ok) begin
                case (state_q)
                    WAIT_DX: begin bx_d = byte_if.BYTE_IN; state_d = WAIT_DY;  end
                    WAIT_DY: begin by_d = byte_if.BYTE_IN; state_d = AFTER_DY; end
`ifdef MOUSE_SCROLL_EN
                    WAIT_DZ: begin bz_d = byte_if.BYTE_IN[3:0]; state_d = UPDATE; end
`endif
                    default: state_d = IDLE;
                endcase
            end else if (cnt_q == CNT_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            // IDLE and UPDATE both accept a new status byte, so none is lost
            state_d = IDLE;
            if (byte_ok && byte_if.BYTE_IN[SYNC]) begin
                status_d = byte_if.BYTE_IN;
                state_d  = WAIT_DX;
            end
        end
        if (!ENABLE) begin
            state_d = IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    mouse_axis_clamp #(.LIMIT(MAX_X), .SUBTRACT(1'b0)) u_clamp_x (
        .pos_i   (x_q),
        .delta_i ({status_q[X_SIGN], bx_q}),
        .ovf_i   (status_q[X_OVF]),
        .pos_o   (x_next)
    );

    // Screen Y grows downward while PS/2 dy is positive upward
    mouse_axis_clamp #(.LIMIT(MAX_Y), .SUBTRACT(1'b1)) u_clamp_y (
        .pos_i   (y_q),
        .delta_i ({status_q[Y_SIGN], by_q}),
        .ovf_i   (status_q[Y_OVF]),
        .pos_o   (y_next)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            status_q     <= 8'd0;
            bx_q         <= 8'd0;
            by_q         <= 8'd0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            status_out_q <= 4'd0;
            x_q          <= 8'(MAX_X / 2);
            y_q          <= 8'(MAX_Y / 2);
            int_q        <= 1'b0;
`ifdef MOUSE_SCROLL_EN
            bz_q         <= 4'd0;
            z_q          <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            int_q    <= upd;
`ifdef MOUSE_SCROLL_EN
            bz_q     <= bz_d;
`endif
            if (upd) begin
                status_out_q <= status_q[3:0];
                x_q          <= x_next;
                y_q          <= y_next;
`ifdef MOUSE_SCROLL_EN
                z_q          <= z_q + {{4{bz_q[3]}}, bz_q};
`endif
            end
        end
    end

    assign MouseStatus   = status_out_q;
    assign MouseX        = x_q;
    assign MouseY        = y_q;
    assign SendInterrupt = int_q;
    assign PACKET_ERR    = err_q;
`ifdef MOUSE_SCROLL_EN
    assign MouseZ        = z_q;
`endif
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder: a packet-level model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_mouse_packet_decoder;
    import mouse_pkg::*;

    localparam int T     = 20;
    localparam int MAXX  = 160;
    localparam int MAXY  = 120;
`ifdef MOUSE_SCROLL_EN
    localparam int PKT_LEN = 4;
`else
    localparam int PKT_LEN = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    mouse_byte_if bif ();
    logic [3:0] st;
    logic [7:0] mx, my;
    logic       sint, perr;
`ifdef MOUSE_SCROLL_EN
    logic [7:0] mz;
`endif

    mouse_packet_decoder #(.MAX_X(MAXX), .MAX_Y(MAXY), .TIMEOUT_CYCLES(T)) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .ENABLE        (enable),
        .byte_if       (bif),
        .MouseStatus   (st),
        .MouseX        (mx),
        .MouseY        (my),
`ifdef MOUSE_SCROLL_EN
        .MouseZ        (mz),
`endif
        .SendInterrupt (sint),
        .PACKET_ERR    (perr)
    );

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;
    int n_int  = 0;
    int n_err  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- packet-level model ----------------
    int         m_x = MAXX / 2, m_y = MAXY / 2, m_z = 0, m_st = 0;
    bit         m_int = 1'b0, m_err = 1'b0;
    logic [7:0] pkt[$];
    logic [7:0] pend_pkt[$];
    bit         pend = 1'b0;
    int         idle = 0;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic apply_pkt();
        int s, dx, dy;
        s  = int'(pend_pkt[0]);
        dx = (s & 16) ? int'(pend_pkt[1]) - 256 : int'(pend_pkt[1]);
        dy = (s & 32) ? int'(pend_pkt[2]) - 256 : int'(pend_pkt[2]);
        if (s & 64)  dx = 0;
        if (s & 128) dy = 0;
        m_x   = clampi(m_x + dx, MAXX - 1);
        m_y   = clampi(m_y - dy, MAXY - 1);
        m_st  = s & 15;
        m_int = 1'b1;
`ifdef MOUSE_SCROLL_EN
        begin
            int nib;
            nib = int'(pend_pkt[3]) & 15;
            if (nib >= 8) nib -= 16;
            m_z = (m_z + nib) & 255;
        end
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x = MAXX / 2; m_y = MAXY / 2; m_z = 0; m_st = 0;
            m_int = 1'b0; m_err = 1'b0; pend = 1'b0; idle = 0;
            pkt.delete();
        end else begin
            m_int = 1'b0;
            m_err = 1'b0;
            if (pend && enable) apply_pkt();
            pend = 1'b0;
            if (!enable) begin
                pkt.delete();
                idle = 0;
            end else if (bif.BYTE_VALID) begin
                if (pkt.size() == 0) begin
                    if (bif.BYTE_ERR == 2'b00 && bif.BYTE_IN[3]) begin
                        pkt.push_back(bif.BYTE_IN);
                        idle = 0;
                    end
                end else if (bif.BYTE_ERR != 2'b00) begin
                    pkt.delete();
                    m_err = 1'b1;
                end else begin
                    pkt.push_back(bif.BYTE_IN);
                    idle = 0;
                    if (pkt.size() == PKT_LEN) begin
                        pend_pkt = pkt;
                        pend = 1'b1;
                        pkt.delete();
                    end
                end
            end else if (pkt.size() != 0) begin
                idle++;
                if (idle == T) begin
                    m_err = 1'b1;
                    pkt.delete();
                    idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("x", int'(mx), m_x);
            check("y", int'(my), m_y);
            check("status", int'(st), m_st);
            check("send_int", int'(sint), int'(m_int));
            check("packet_err", int'(perr), int'(m_err));
            check("int_err_exclusive", int'(sint & perr), 0);
`ifdef MOUSE_SCROLL_EN
            check("z", int'(mz), m_z);
`endif
            n_int += int'(sint);
            n_err += int'(perr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] b, input logic [1:0] e);
        bif.BYTE_IN    = b;
        bif.BYTE_ERR   = e;
        bif.BYTE_VALID = 1'b1;
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        bif.BYTE_VALID = 1'b0;
        bif.BYTE_ERR   = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] e);
        drive(b, e);
        quiet(1);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0, 2'b00);
        send(b1, 2'b00);
        send(b2, 2'b00);
`ifdef MOUSE_SCROLL_EN
        send(8'h01, 2'b00);
`endif
        quiet(3);
        $display("pkt %02h %02h %02h -> X=%0d Y=%0d status=%h", b0, b1, b2, mx, my, st);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int a_int, a_err;

    initial begin
        bif.BYTE_IN = 8'h00; bif.BYTE_VALID = 1'b0; bif.BYTE_ERR = 2'b00;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_x", int'(mx), 8'h50);
        check("rst_y", int'(my), 8'h3C);
        check("rst_status", int'(st), 0);
        check("rst_int", int'(sint), 0);
        check("rst_err", int'(perr), 0);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);

        // normal packet with explicit latency checks
        send(8'h09, 2'b00);
        send(8'h05, 2'b00);
`ifdef MOUSE_SCROLL_EN
        send(8'h03, 2'b00);
        drive(8'h00, 2'b00);
`else
        drive(8'h03, 2'b00);
`endif
        quiet(0);
        check("lat_int_k", int'(sint), 0);
        @(negedge clk);
        check("lat_int_k1", int'(sint), 1);
        check("norm_x", int'(mx), 85);
        check("norm_y", int'(my), 57);
        check("norm_status", int'(st), 9);
        @(negedge clk);
        check("lat_int_k2", int'(sint), 0);
        $display("pkt 09 05 03 -> X=%0d Y=%0d status=%h", mx, my, st);

        // reset mid-packet
        send(8'h09, 2'b00);
        send(8'h05, 2'b00);
        a_int = n_int; a_err = n_err;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x", int'(mx), 8'h50);
        check("midrst_y", int'(my), 8'h3C);
        check("midrst_status", int'(st), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_pulses", n_int - a_int + n_err - a_err, 0);
        send_pkt(8'h09, 8'h05, 8'h03);
        check("after_rst_x", int'(mx), 85);
        check("after_rst_y", int'(my), 57);

        // clamping
        do_reset();
        send_pkt(8'h18, 8'h9C, 8'h00);
        check("clamp_x_low", int'(mx), 0);
        send_pkt(8'h08, 8'h7F, 8'h00);
        check("clamp_x_127", int'(mx), 127);
        send_pkt(8'h08, 8'h7F, 8'h00);
        check("clamp_x_high", int'(mx), 159);
        send_pkt(8'h28, 8'h00, 8'h80);
        check("clamp_y_high", int'(my), 119);

        // overflow
        do_reset();
        a_int = n_int;
        send_pkt(8'h48, 8'h7F, 8'h00);
        check("ovf_x", int'(mx), 80);
        check("ovf_status", int'(st), 8);
        check("ovf_int_count", n_int - a_int, 1);

        // resync
        a_int = n_int;
        send(8'h00, 2'b00);
        send_pkt(8'h09, 8'h01, 8'h00);
        check("resync_x", int'(mx), 81);
        check("resync_int_count", n_int - a_int, 1);

        // back-to-back: next status byte arrives in the update cycle
        a_int = n_int;
        drive(8'h09, 2'b00); drive(8'h01, 2'b00); drive(8'h00, 2'b00);
        drive(8'h09, 2'b00); drive(8'h01, 2'b00); drive(8'h00, 2'b00);
        quiet(3);
        $display("b2b 09 01 00 x2 -> X=%0d", mx);
        check("b2b_x", int'(mx), 83);
        check("b2b_int_count", n_int - a_int, 2);

        // byte error inside a packet
        a_int = n_int; a_err = n_err;
        send(8'h09, 2'b00);
        send(8'h05, 2'b01);
        send(8'h03, 2'b00);
        quiet(3);
        $display("byte err in packet -> errs=%0d ints=%0d", n_err - a_err, n_int - a_int);
        check("byteerr_err_count", n_err - a_err, 1);
        check("byteerr_int_count", n_int - a_int, 0);
        check("byteerr_x", int'(mx), 83);

        // byte error in idle is silently dropped
        a_int = n_int; a_err = n_err;
        send(8'h09, 2'b10);
        send(8'h05, 2'b00);
        send(8'h03, 2'b00);
        quiet(3);
        check("idleerr_pulses", n_int - a_int + n_err - a_err, 0);

        // timeout
        a_int = n_int; a_err = n_err;
        send(8'h09, 2'b00);
        quiet(T + 2);
        check("timeout_err_count", n_err - a_err, 1);
        send(8'h05, 2'b00);
        send(8'h03, 2'b00);
        quiet(3);
        $display("timeout -> errs=%0d ints=%0d", n_err - a_err, n_int - a_int);
        check("timeout_int_count", n_int - a_int, 0);
        check("timeout_x", int'(mx), 83);

        // enable drop mid-packet
        a_int = n_int; a_err = n_err;
        send(8'h09, 2'b00);
        send(8'h05, 2'b00);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        send(8'h03, 2'b00);
        quiet(3);
        check("enable_drop_pulses", n_int - a_int + n_err - a_err, 0);
        send_pkt(8'h09, 8'h02, 8'h01);
        check("enable_after_x", int'(mx), 85);
        check("enable_after_y", int'(my), 59);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
